// File: rtl/mul_limb_seq.sv
// Sequential unsigned multiplier: one LIMB x LIMB partial product per clock,
// schoolbook order, accumulated into a 2*WIDTH register with a start/busy/done handshake.
module mul_limb_seq #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   out,
  output logic                 done
);

  localparam int N    = WIDTH / LIMB;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if (((WIDTH % LIMB) != 0) || (WIDTH < LIMB)) begin : g_bad_params
    $error("mul_limb_seq: WIDTH must be a non-zero multiple of LIMB");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   out_q, out_d;
  logic [IDXW-1:0]      i_q, i_d;
  logic [IDXW-1:0]      j_q, j_d;

  logic [LIMB-1:0]      a_limbs [N];
  logic [LIMB-1:0]      b_limbs [N];
  logic [LIMB-1:0]      a_limb;
  logic [LIMB-1:0]      b_limb;
  logic [2*LIMB-1:0]    prod;
  logic [IDXW:0]        ij_sum;
  logic [2*WIDTH-1:0]   pp_shifted;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_step;

  for (genvar gi = 0; gi < N; gi++) begin : g_limbs
    assign a_limbs[gi] = a_q[gi*LIMB +: LIMB];
    assign b_limbs[gi] = b_q[gi*LIMB +: LIMB];
  end

  // The only multiplier in the design; everything else is shift and add.
  assign a_limb     = a_limbs[i_q];
  assign b_limb     = b_limbs[j_q];
  assign prod       = a_limb * b_limb;
  assign ij_sum     = {1'b0, i_q} + {1'b0, j_q};
  assign pp_shifted = (2*WIDTH)'(prod) << (LIMB * int'(ij_sum));
  assign acc_sum    = acc_q + pp_shifted;
  assign last_step  = (i_q == LAST_IDX) && (j_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    i_d     = i_q;
    j_d     = j_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done    = (state_q == S_DONE);
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        acc_d = acc_sum;
        if (j_q == LAST_IDX) begin
          j_d = '0;
          i_d = i_q + IDXW'(1);
        end else begin
          j_d = j_q + IDXW'(1);
        end
        if (last_step) begin
          out_d   = acc_sum;
          i_d     = '0;
          j_d     = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mul_limb_seq.sv
// Directed and randomized checks of mul_limb_seq at WIDTH=16 and WIDTH=256,
// with products predicted by plain wide multiplication.
module tb_mul_limb_seq;

  logic         clk = 1'b0;
  logic         reset;

  logic         start16;
  logic [15:0]  a16, b16;
  logic         busy16, done16;
  logic [31:0]  out16;

  logic         start256;
  logic [255:0] a256, b256;
  logic         busy256, done256;
  logic [511:0] out256;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_limb_seq #(.WIDTH(16), .LIMB(8)) dut16 (
    .clk   (clk),
    .reset (reset),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .busy  (busy16),
    .out   (out16),
    .done  (done16)
  );

  mul_limb_seq #(.WIDTH(256), .LIMB(8)) dut256 (
    .clk   (clk),
    .reset (reset),
    .start (start256),
    .a     (a256),
    .b     (b256),
    .busy  (busy256),
    .out   (out256),
    .done  (done256)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_done(input bit wide);
    return wide ? done256 : done16;
  endfunction

  function automatic logic [511:0] cur_out(input bit wide);
    return wide ? out256 : 512'(out16);
  endfunction

  // Start one product, scramble the operand inputs afterwards, and check
  // latency (edges from accept to done) and the exact product.
  task automatic do_op(input bit wide, input logic [255:0] av, input logic [255:0] bv,
                       input string tag);
    logic [511:0] exp;
    int lat;
    int cyc;
    if (wide) begin
      exp = {256'b0, av} * {256'b0, bv};
      lat = 1024;
      start256 = 1'b1; a256 = av; b256 = bv;
    end else begin
      exp = 512'(av[15:0]) * 512'(bv[15:0]);
      lat = 4;
      start16 = 1'b1; a16 = av[15:0]; b16 = bv[15:0];
    end
    tick;
    start16 = 1'b0; start256 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    a256 = ~av; b256 = ~bv;
    cyc = 0;
    while (!cur_done(wide) && cyc < lat + 50) begin
      tick;
      cyc++;
    end
    chk({tag, ".lat"}, 512'(cyc), 512'(lat));
    chk({tag, ".out"}, cur_out(wide), exp);
    tick;
    chk({tag, ".done_drop"}, 512'(cur_done(wide)), 512'(0));
    $display("op %s a=%0h b=%0h out=%0h latency=%0d", tag, av, bv, cur_out(wide), cyc);
  endtask

  initial begin
    logic [255:0] ra, rb;
    logic [511:0] emax;
    int nd;

    reset = 1'b1;
    start16 = 1'b1; a16 = 16'h0003; b16 = 16'h0005;
    start256 = 1'b1; a256 = 256'd3; b256 = 256'd5;

    // Reset held two cycles with start asserted.
    tick;
    tick;
    chk("rst.out16", 512'(out16), 512'(0));
    chk("rst.done16", 512'(done16), 512'(0));
    chk("rst.busy16", 512'(busy16), 512'(0));
    chk("rst.out256", out256, 512'(0));
    chk("rst.busy256", 512'(busy256), 512'(0));
    reset = 1'b0; start16 = 1'b0; start256 = 1'b0;
    tick;
    chk("rst.nostart16", 512'(busy16), 512'(0));
    chk("rst.nostart256", 512'(busy256), 512'(0));
    $display("reset sequence done");

    // 0xFFFF * 0xFFFF with cycle-by-cycle busy/done checks.
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF;
    tick;
    start16 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("max16.busy", 512'(busy16), 512'(1));
      chk("max16.done_early", 512'(done16), 512'(0));
      tick;
    end
    chk("max16.done", 512'(done16), 512'(1));
    chk("max16.busy_off", 512'(busy16), 512'(0));
    chk("max16.out", 512'(out16), 512'(32'hFFFE0001));
    tick;
    chk("max16.done_drop", 512'(done16), 512'(0));
    chk("max16.hold", 512'(out16), 512'(32'hFFFE0001));
    $display("op max16 out=%0h", out16);

    do_op(1'b0, 256'h1234, 256'h5678, "m16b");
    chk("m16b.const", 512'(out16), 512'(32'h06260060));

    // Start pulsed while busy must be ignored.
    start16 = 1'b1; a16 = 16'd3; b16 = 16'd5;
    tick;
    start16 = 1'b0;
    tick;
    start16 = 1'b1; a16 = 16'd7; b16 = 16'd7;
    tick;
    start16 = 1'b0;
    tick;
    tick;
    chk("ign.done", 512'(done16), 512'(1));
    chk("ign.out", 512'(out16), 512'(15));
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (done16) nd++;
    end
    chk("ign.no_second_done", 512'(nd), 512'(0));
    chk("ign.hold", 512'(out16), 512'(15));
    $display("op busy-ignore out=%0h extra_dones=%0d", out16, nd);

    // Back-to-back: start held high, new operands presented during DONE.
    start16 = 1'b1; a16 = 16'd2; b16 = 16'd3;
    tick;
    for (int c = 0; c < 4; c++) tick;
    chk("b2b.done1", 512'(done16), 512'(1));
    chk("b2b.out1", 512'(out16), 512'(6));
    a16 = 16'h0100; b16 = 16'h0100;
    tick;
    chk("b2b.accept", 512'(busy16), 512'(1));
    chk("b2b.done_gap", 512'(done16), 512'(0));
    start16 = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    chk("b2b.done2", 512'(done16), 512'(1));
    chk("b2b.out2", 512'(out16), 512'(32'h00010000));
    tick;
    chk("b2b.idle", 512'(busy16), 512'(0));
    $display("op back-to-back out=%0h", out16);

    for (int k = 0; k < 200; k++) begin
      ra = 256'($urandom_range(0, 65535));
      rb = 256'($urandom_range(0, 65535));
      if (k == 0) ra = 256'd0;
      do_op(1'b0, ra, rb, "r16");
    end

    // WIDTH=256 all-ones operands.
    emax = 512'd0 - (512'd1 << 257) + 512'd1;
    do_op(1'b1, {256{1'b1}}, {256{1'b1}}, "max256");
    chk("max256.const", out256, emax);

    // Abort a run with reset.
    start256 = 1'b1;
    for (int w = 0; w < 8; w++) begin
      a256[w*32 +: 32] = $urandom;
      b256[w*32 +: 32] = $urandom;
    end
    tick;
    start256 = 1'b0;
    repeat (499) tick;
    chk("abort.busy_before", 512'(busy256), 512'(1));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort.busy", 512'(busy256), 512'(0));
    chk("abort.out", out256, 512'(0));
    nd = 0;
    for (int c = 0; c < 1100; c++) begin
      tick;
      if (done256) nd++;
    end
    chk("abort.no_done", 512'(nd), 512'(0));
    chk("abort.out_hold", out256, 512'(0));
    $display("abort sequence dones=%0d out=%0h", nd, out256);

    do_op(1'b1, 256'd1, 256'd1, "one256");
    ra = '0;
    for (int w = 0; w < 8; w++) ra[w*32 +: 32] = $urandom;
    do_op(1'b1, 256'd0, ra, "zero256");

    for (int k = 0; k < 25; k++) begin
      for (int w = 0; w < 8; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      do_op(1'b1, ra, rb, "r256");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
